// File: rtl/hier_pkg.sv
// ---------------------------------------------------------------------------
// hier_pkg
//   Shared types and helpers for the hierarchy fan-out dispatcher slice.
//   - NUM_LANES_DEFAULT : child count of the hierarchy node this stage feeds
//   - lane_idx_t        : lane index type sized for the default lane count
//   - disp_state_e      : holding-register occupancy state
//   - sat_inc           : saturating increment used by the statistics counters
// ---------------------------------------------------------------------------
package hier_pkg;

  localparam int NUM_LANES_DEFAULT = 10;

  typedef logic [$clog2(NUM_LANES_DEFAULT)-1:0] lane_idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } disp_state_e;

  // Operates on a 64-bit container so one function serves every counter
  // width; callers zero-extend in and truncate out.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic [63:0] max_value);
    return (value >= max_value) ? max_value : value + 64'd1;
  endfunction

endpackage

// File: rtl/hier_fanout_dispatcher_if.sv
// ---------------------------------------------------------------------------
// hier_fanout_dispatcher_if
//   Bundles the dispatcher's input stream and its per-lane output handshake.
//   master : the environment (upstream source + downstream child lanes)
//   slave  : the dispatcher itself
//   Signals:
//     in_valid/in_ready/in_data/in_directed/in_lane : input beat stream
//     lane_valid/lane_ready                          : per-lane handshake
//     lane_data                                      : shared payload bus
// ---------------------------------------------------------------------------
interface hier_fanout_dispatcher_if #(
  parameter int NUM_LANES = 10,
  parameter int DATA_W    = 32
);
  localparam int LANE_W = $clog2(NUM_LANES);

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic                 in_directed;
  logic [LANE_W-1:0]    in_lane;
  logic [NUM_LANES-1:0] lane_valid;
  logic [NUM_LANES-1:0] lane_ready;
  logic [DATA_W-1:0]    lane_data;

  modport master (
    output in_valid, in_data, in_directed, in_lane, lane_ready,
    input  in_ready, lane_valid, lane_data
  );

  modport slave (
    input  in_valid, in_data, in_directed, in_lane, lane_ready,
    output in_ready, lane_valid, lane_data
  );

endinterface

// File: rtl/hier_sat_counter.sv
// ---------------------------------------------------------------------------
// hier_sat_counter
//   Statistics counter that sticks at its all-ones value instead of wrapping.
//   Ports:
//     clk   : clock
//     rst   : synchronous active-high clear
//     inc   : count one event this cycle
//     count : current value
// ---------------------------------------------------------------------------
module hier_sat_counter
  import hier_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [63:0] MAX_VALUE = (64'd1 << WIDTH) - 64'd1;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= WIDTH'(sat_inc(64'(count), MAX_VALUE));
    end
  end

endmodule

// File: rtl/hier_fanout_dispatcher.sv
// ---------------------------------------------------------------------------
// hier_fanout_dispatcher
//   Single-entry distribution stage in front of a NUM_LANES-way hierarchy
//   node. Each accepted beat goes to exactly one lane, chosen either by a
//   round-robin pointer or by the lane index carried with the beat. Directed
//   beats naming a non-existent lane are swallowed and counted as drops.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     bus        : input stream + per-lane handshake (slave modport)
//     rr_ptr     : lane the next round-robin beat will take
//     accept_cnt : beats delivered to a lane (saturating)
//     drop_cnt   : directed beats dropped for an illegal lane (saturating)
//     busy       : holding register occupied
// ---------------------------------------------------------------------------
module hier_fanout_dispatcher
  import hier_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEFAULT,
  parameter int DATA_W    = 32,
  parameter int LANE_W    = $clog2(NUM_LANES),
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  hier_fanout_dispatcher_if.slave bus,
  output logic [LANE_W-1:0] rr_ptr,
  output logic [CNT_W-1:0]  accept_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              busy
);

  localparam logic [LANE_W:0]   LANE_LIMIT = (LANE_W+1)'(NUM_LANES);
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(NUM_LANES - 1);

  disp_state_e          state_q;
  logic [LANE_W-1:0]    held_lane_q;
  logic [DATA_W-1:0]    held_data_q;
  logic [NUM_LANES-1:0] lane_valid_q;
  logic [LANE_W-1:0]    rr_q;

  logic              drain;
  logic              accept;
  logic              illegal;
  logic              legal_accept;
  logic [LANE_W-1:0] sel_lane;

  // NOTE: every signal driven here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    drain        = (state_q == FULL) && bus.lane_ready[held_lane_q];
    // Combinational path from lane_ready keeps one beat per cycle while the
    // holding register is draining.
    bus.in_ready = (state_q == EMPTY) || drain;
    accept       = bus.in_valid && bus.in_ready;
    illegal      = bus.in_directed && ({1'b0, bus.in_lane} >= LANE_LIMIT);
    legal_accept = accept && !illegal;
    sel_lane     = bus.in_directed ? bus.in_lane : rr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      held_lane_q  <= '0;
      held_data_q  <= '0;
      lane_valid_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (legal_accept) begin
            state_q      <= FULL;
            held_lane_q  <= sel_lane;
            held_data_q  <= bus.in_data;
            lane_valid_q <= NUM_LANES'(1) << sel_lane;
          end
        end
        FULL: begin
          // While FULL, in_ready implies a drain, so a legal accept here is
          // always a same-edge reload with no bubble.
          if (legal_accept) begin
            held_lane_q  <= sel_lane;
            held_data_q  <= bus.in_data;
            lane_valid_q <= NUM_LANES'(1) << sel_lane;
          end else if (drain) begin
            state_q      <= EMPTY;
            lane_valid_q <= '0;
          end
        end
        default: begin
          state_q      <= EMPTY;
          lane_valid_q <= '0;
        end
      endcase
    end
  end

  // The pointer advances on every round-robin accept, whether or not the
  // chosen lane is ready, so no lane is ever skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else if (legal_accept && !bus.in_directed) begin
      rr_q <= (rr_q == LAST_LANE) ? '0 : rr_q + LANE_W'(1);
    end
  end

  hier_sat_counter #(.WIDTH(CNT_W)) u_accept_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drain),
    .count (accept_cnt)
  );

  hier_sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept && illegal),
    .count (drop_cnt)
  );

  assign bus.lane_valid = lane_valid_q;
  assign bus.lane_data  = held_data_q;
  assign rr_ptr         = rr_q;
  assign busy           = (state_q == FULL);

  a_lane_valid_onehot0 : assert property (
    @(posedge clk) disable iff (rst) $onehot0(bus.lane_valid)
  );

endmodule

// File: tb/tb_hier_fanout_dispatcher.sv
module tb_hier_fanout_dispatcher;
  import hier_pkg::*;

  localparam int NL      = NUM_LANES_DEFAULT;
  localparam int DW      = 32;
  localparam int CW      = 4;
  localparam int LW      = $clog2(NL);
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [LW-1:0] rr_ptr;
  logic [CW-1:0] accept_cnt;
  logic [CW-1:0] drop_cnt;
  logic          busy;

  int checks = 0;
  int errors = 0;

  hier_fanout_dispatcher_if #(.NUM_LANES(NL), .DATA_W(DW)) bus ();

  hier_fanout_dispatcher #(
    .NUM_LANES (NL),
    .DATA_W    (DW),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rr_ptr     (rr_ptr),
    .accept_cnt (accept_cnt),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: at most one pending delivery, a round-robin counter
  // kept as a plain integer, and two statistics tallies clamped at CNT_MAX.
  typedef struct { int lane; logic [DW-1:0] data; } beat_t;
  beat_t pending[$];
  int    m_rr;
  int    m_acc;
  int    m_drop;

  function automatic logic [NL-1:0] exp_valid();
    if (pending.size() == 0) return '0;
    return NL'(1) << pending[0].lane;
  endfunction

  function automatic logic exp_ready();
    if (pending.size() == 0) return 1'b1;
    return bus.lane_ready[pending[0].lane];
  endfunction

  task automatic model_reset();
    pending.delete();
    m_rr   = 0;
    m_acc  = 0;
    m_drop = 0;
  endtask

  // Drive inputs just after a falling edge; outputs settle by #1.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic dir,
                       input lane_idx_t lane, input logic [NL-1:0] ready);
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.in_directed = dir;
    bus.in_lane     = lane;
    bus.lane_ready  = ready;
    #1;
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    logic          drained;
    logic          took;
    logic          dir;
    int            lane;
    logic [DW-1:0] data;
    beat_t         b;
    drained = (pending.size() != 0) && bus.lane_ready[pending[0].lane];
    took    = bus.in_valid && exp_ready();
    dir     = bus.in_directed;
    lane    = int'(bus.in_lane);
    data    = bus.in_data;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (drained) begin
        void'(pending.pop_front());
        if (m_acc < CNT_MAX) m_acc++;
      end
      if (took) begin
        if (dir && lane >= NL) begin
          if (m_drop < CNT_MAX) m_drop++;
        end else begin
          b.lane = dir ? lane : m_rr;
          b.data = data;
          pending.push_back(b);
          if (!dir) m_rr = (m_rr + 1) % NL;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, '0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    if (bus.lane_valid !== '0) begin errors++; $display("FAIL reset_lane_valid got %h want 0", bus.lane_valid); end
    if (bus.lane_data !== '0) begin errors++; $display("FAIL reset_lane_data got %h want 0", bus.lane_data); end
    if (rr_ptr !== '0) begin errors++; $display("FAIL reset_rr_ptr got %0d want 0", rr_ptr); end
    if (accept_cnt !== '0) begin errors++; $display("FAIL reset_accept_cnt got %0d want 0", accept_cnt); end
    if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
  endtask

  task automatic test_round_robin();
    logic [NL-1:0] want_v;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, DW'(32'hA0 + i), 1'b0, '0, '1);
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rr_in_ready beat %0d got %0b want 1", i, bus.in_ready); end
      if (i > 0) begin
        want_v = NL'(1) << ((i - 1) % NL);
        checks += 2;
        if (bus.lane_valid !== want_v) begin errors++; $display("FAIL rr_lane_valid beat %0d got %h want %h", i, bus.lane_valid, want_v); end
        if (bus.lane_data !== DW'(32'hA0 + i - 1)) begin errors++; $display("FAIL rr_lane_data beat %0d got %h want %h", i, bus.lane_data, 32'hA0 + i - 1); end
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, '1);
    checks += 2;
    if (bus.lane_valid !== NL'(2)) begin errors++; $display("FAIL rr_last_lane got %h want 002", bus.lane_valid); end
    if (bus.lane_data !== DW'(32'hAB)) begin errors++; $display("FAIL rr_last_data got %h want ab", bus.lane_data); end
    tick();
    checks += 3;
    if (accept_cnt !== CW'(12)) begin errors++; $display("FAIL rr_accept_cnt got %0d want 12", accept_cnt); end
    if (rr_ptr !== LW'(2)) begin errors++; $display("FAIL rr_ptr got %0d want 2", rr_ptr); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy_after got %0b want 0", busy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, DW'(32'h55), 1'b1, lane_idx_t'(3), ~NL'(10'h008));
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(32'h99), 1'b0, '0, ~NL'(10'h008));
      checks += 4;
      if (bus.lane_valid !== NL'(10'h008)) begin errors++; $display("FAIL bp_lane_valid cyc %0d got %h want 008", i, bus.lane_valid); end
      if (bus.lane_data !== DW'(32'h55)) begin errors++; $display("FAIL bp_lane_data cyc %0d got %h want 55", i, bus.lane_data); end
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %0b want 0", i, bus.in_ready); end
      if (accept_cnt !== '0) begin errors++; $display("FAIL bp_accept_cnt cyc %0d got %0d want 0", i, accept_cnt); end
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, '1);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b want 1", bus.in_ready); end
    tick();
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_drain_busy got %0b want 0", busy); end
    if (bus.lane_valid !== '0) begin errors++; $display("FAIL bp_drain_valid got %h want 0", bus.lane_valid); end
    if (accept_cnt !== CW'(1)) begin errors++; $display("FAIL bp_drain_cnt got %0d want 1", accept_cnt); end
    if (rr_ptr !== '0) begin errors++; $display("FAIL bp_rr_ptr got %0d want 0", rr_ptr); end
  endtask

  task automatic test_directed();
    do_reset();
    drive(1'b1, DW'(32'h77), 1'b1, lane_idx_t'(7), '1);
    tick();
    drive(1'b1, DW'(32'hCC), 1'b1, lane_idx_t'(12), '1);
    checks += 3;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL dir_illegal_ready got %0b want 1", bus.in_ready); end
    if (bus.lane_valid !== NL'(10'h080)) begin errors++; $display("FAIL dir_lane_valid got %h want 080", bus.lane_valid); end
    if (bus.lane_data !== DW'(32'h77)) begin errors++; $display("FAIL dir_lane_data got %h want 77", bus.lane_data); end
    tick();
    drive(1'b0, '0, 1'b0, '0, '1);
    checks += 5;
    if (bus.lane_valid !== '0) begin errors++; $display("FAIL dir_drop_valid got %h want 0", bus.lane_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL dir_drop_busy got %0b want 0", busy); end
    if (drop_cnt !== CW'(1)) begin errors++; $display("FAIL dir_drop_cnt got %0d want 1", drop_cnt); end
    if (accept_cnt !== CW'(1)) begin errors++; $display("FAIL dir_accept_cnt got %0d want 1", accept_cnt); end
    if (rr_ptr !== '0) begin errors++; $display("FAIL dir_rr_ptr got %0d want 0", rr_ptr); end
    tick();
    checks++;
    if (bus.lane_valid !== '0) begin errors++; $display("FAIL dir_never_shown got %h want 0", bus.lane_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, DW'(32'h10), 1'b0, '0, '1);
    tick();
    drive(1'b1, DW'(32'h11), 1'b0, '0, '1);
    checks += 2;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %0b want 1", bus.in_ready); end
    if (bus.lane_valid !== NL'(1)) begin errors++; $display("FAIL b2b_first_lane got %h want 001", bus.lane_valid); end
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    checks += 5;
    if (bus.lane_valid !== NL'(2)) begin errors++; $display("FAIL b2b_next_lane got %h want 002", bus.lane_valid); end
    if (bus.lane_data !== DW'(32'h11)) begin errors++; $display("FAIL b2b_next_data got %h want 11", bus.lane_data); end
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %0b want 1", busy); end
    if (accept_cnt !== CW'(1)) begin errors++; $display("FAIL b2b_accept_cnt got %0d want 1", accept_cnt); end
    if (rr_ptr !== LW'(2)) begin errors++; $display("FAIL b2b_rr_ptr got %0d want 2", rr_ptr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, DW'(32'h01), 1'b0, '0, '1);
    tick();
    drive(1'b1, DW'(32'h02), 1'b1, lane_idx_t'(13), '1);
    tick();
    drive(1'b1, DW'(32'h5A), 1'b1, lane_idx_t'(5), '0);
    tick();
    drive(1'b1, DW'(32'h66), 1'b0, '0, '0);
    checks += 4;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy got %0b want 1", busy); end
    if (bus.lane_valid !== NL'(10'h020)) begin errors++; $display("FAIL mid_pre_valid got %h want 020", bus.lane_valid); end
    if (accept_cnt !== CW'(1)) begin errors++; $display("FAIL mid_pre_acc got %0d want 1", accept_cnt); end
    if (drop_cnt !== CW'(1)) begin errors++; $display("FAIL mid_pre_drop got %0d want 1", drop_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '1);
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b want 0", busy); end
    if (bus.lane_valid !== '0) begin errors++; $display("FAIL mid_valid got %h want 0", bus.lane_valid); end
    if (accept_cnt !== '0) begin errors++; $display("FAIL mid_acc got %0d want 0", accept_cnt); end
    if (drop_cnt !== '0) begin errors++; $display("FAIL mid_drop got %0d want 0", drop_cnt); end
    if (rr_ptr !== '0) begin errors++; $display("FAIL mid_rr got %0d want 0", rr_ptr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 2;
      if (bus.lane_valid !== '0) begin errors++; $display("FAIL mid_ghost_valid cyc %0d got %h want 0", i, bus.lane_valid); end
      if (accept_cnt !== '0) begin errors++; $display("FAIL mid_ghost_acc cyc %0d got %0d want 0", i, accept_cnt); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, DW'(i), 1'b0, '0, '1);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, DW'(i), 1'b1, lane_idx_t'(14), '1);
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, '1);
    tick();
    checks += 2;
    if (accept_cnt !== CW'(CNT_MAX)) begin errors++; $display("FAIL sat_accept_cnt got %0d want %0d", accept_cnt, CNT_MAX); end
    if (drop_cnt !== CW'(CNT_MAX)) begin errors++; $display("FAIL sat_drop_cnt got %0d want %0d", drop_cnt, CNT_MAX); end
  endtask

  task automatic test_random();
    logic [NL-1:0] ready;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 80 == 79) do_reset();
      ready = NL'($urandom()) | NL'($urandom());
      drive($urandom_range(0, 3) != 0, DW'($urandom()), $urandom_range(0, 2) == 0,
            lane_idx_t'($urandom_range(0, 15)), ready);
      checks += 6;
      if (bus.in_ready !== exp_ready()) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %0b want %0b", i, bus.in_ready, exp_ready()); end
      if (bus.lane_valid !== exp_valid()) begin errors++; $display("FAIL rnd_lane_valid cyc %0d got %h want %h", i, bus.lane_valid, exp_valid()); end
      if (busy !== (pending.size() != 0)) begin errors++; $display("FAIL rnd_busy cyc %0d got %0b want %0b", i, busy, pending.size() != 0); end
      if (rr_ptr !== LW'(m_rr)) begin errors++; $display("FAIL rnd_rr_ptr cyc %0d got %0d want %0d", i, rr_ptr, m_rr); end
      if (accept_cnt !== CW'(m_acc)) begin errors++; $display("FAIL rnd_accept_cnt cyc %0d got %0d want %0d", i, accept_cnt, m_acc); end
      if (drop_cnt !== CW'(m_drop)) begin errors++; $display("FAIL rnd_drop_cnt cyc %0d got %0d want %0d", i, drop_cnt, m_drop); end
      if (pending.size() != 0) begin
        checks++;
        if (bus.lane_data !== pending[0].data) begin errors++; $display("FAIL rnd_lane_data cyc %0d got %h want %h", i, bus.lane_data, pending[0].data); end
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_backpressure();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hier_fanout_dispatcher.md
Name: hier_fanout_dispatcher

Overview:
Front-end distribution stage that sits directly upstream of a 10-way hierarchy node and feeds its child instances. It accepts one valid/ready input stream and routes each beat to exactly one of NUM_LANES downstream lanes. Routing is either strict round-robin or directed by a lane index carried with the beat. It also keeps per-block accept and drop statistics for hierarchy bring-up tests.

Parameters:
NUM_LANES, 10, number of downstream child lanes (2..16)
DATA_W, 32, payload width
LANE_W, $clog2(NUM_LANES), lane index width (derived; do not override)
CNT_W, 16, statistics counter width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid && in_ready
in_data  input  DATA_W  input payload
in_directed  input  1  1 = route to in_lane; 0 = round-robin
in_lane  input  LANE_W  target lane when in_directed=1
lane_valid  output  NUM_LANES  one-hot-or-zero valid per lane
lane_ready  input  NUM_LANES  per-lane ready
lane_data  output  DATA_W  shared payload bus, qualified by lane_valid
rr_ptr  output  LANE_W  next round-robin lane
accept_cnt  output  CNT_W  beats delivered to a lane
drop_cnt  output  CNT_W  directed beats dropped for an illegal lane
busy  output  1  holding register occupied

Behaviour:
- Reset (rst=1 at clk edge): lane_valid=0, lane_data=0, rr_ptr=0, accept_cnt=0, drop_cnt=0, busy=0, state=EMPTY. rst wins over every other event. A held beat is discarded without counting.
- Storage: one holding register (data + lane index). FSM has two states:
  - EMPTY: busy=0, lane_valid=0.
  - FULL: busy=1, lane_valid = one-hot of held lane; lane_data = held data.
- in_ready = (state==EMPTY) || (lane_ready[held_lane] && lane_valid[held_lane]). This is a combinational path from lane_ready. It allows 1 beat/cycle throughput.
- Latency: a beat accepted at edge N drives lane_valid from cycle N+1. The beat is delivered at the first edge where its lane_ready=1.
- Lane selection on accept:
  - Round-robin: lane = rr_ptr, then rr_ptr increments with wrap NUM_LANES-1 -> 0. The pointer never skips a lane, even if that lane is not ready.
  - Directed, in_lane < NUM_LANES: lane = in_lane; rr_ptr is unchanged.
  - Directed, in_lane >= NUM_LANES: the beat is accepted, never stored, and drop_cnt increments. The state is unchanged, except that a simultaneous drain still takes effect.
- Transitions:
  - EMPTY -> FULL on a legal accept.
  - FULL -> EMPTY on a drain with no legal accept.
  - FULL -> FULL on a drain with a simultaneous legal accept; the holding register reloads in the same edge.
  - FULL with no drain: the held data and lane stay stable (valid/data stability rule).
- accept_cnt increments on each drain (lane_valid[i] && lane_ready[i]).
- Both counters saturate at 2^CNT_W-1 and do not wrap.
- lane_ready on non-selected lanes is ignored. lane_valid has at most one bit set (checked by assertion).

Decomposition:
- Shared package hier_pkg holds NUM_LANES_DEFAULT=10, a lane_idx_t typedef, a disp_state_e enum {EMPTY, FULL}, and a sat_inc function.
- One sub-module, hier_sat_counter (width param, inc, rst, count), is instantiated twice.
- The FSM, holding register and rr pointer stay inline.

Test Plan:
1. Reset and idle: after rst, all lane_ready=1 and 12 round-robin beats 0xA0..0xAB back-to-back. Required: lanes 0..9,0,1 each receive one beat starting the cycle after the first accept. accept_cnt=12, rr_ptr=2, and in_ready stays high throughout.
2. Backpressure: hold lane_ready[3]=0 with a beat 0x55 queued for lane 3. Required: lane_valid=0x008 and lane_data=0x55 stay stable, in_ready=0, and accept_cnt is unchanged. Raising lane_ready[3] drains it in 1 cycle.
3. Directed/illegal: directed beat to lane 7 (0x77), then to lane 12 (0xCC). Required: lane 7 gets 0x77, the 0xCC beat is accepted with in_ready=1 and never appears on any lane, drop_cnt=1, and rr_ptr is unchanged.
4. Simultaneous drain+accept: FULL on lane 0 with lane_ready[0]=1 while a new beat is presented. Required: both take effect on the same edge, the next cycle shows the new lane, and there is no bubble.
5. Reset mid-operation: rst asserted while FULL and backpressured. Required: next cycle busy=0, lane_valid=0 and counters=0, and the held beat never drains.
6. Saturation: with CNT_W=4, deliver 20 beats. Required: accept_cnt stops at 15.
